// File: rtl/chiplet_types_pkg.sv
// Shared flit format and helpers for the chiplet link.
package chiplet_types_pkg;

   localparam int VC_ID_W = 2;
   localparam int DATA_W  = 16;

   typedef logic [VC_ID_W-1:0] vc_id_t;

   typedef struct packed {
      logic              head;
      logic              tail;
      vc_id_t            vc;
      logic [DATA_W-1:0] data;
   } flit_t;

   function automatic logic flit_is_tail(flit_t f);
      return f.tail;
   endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO; the head entry is held in an output register so it is
// presented the cycle after it is written.
module vc_fifo
   import chiplet_types_pkg::*;
#(
   parameter int  DEPTH  = 8,
   parameter type data_t = flit_t
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   push,
   input  logic                   pop,
   input  data_t                  wdata,
   output data_t                  rdata,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   data_t          mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr_inc;
   data_t          head_nxt;

   assign rd_ptr_inc = rd_ptr + AW'(1);
   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));

   // A push into an empty (or emptying) FIFO becomes the new head directly.
   always_comb begin
      head_nxt = rdata;
      if (pop) begin
         head_nxt = (count == CW'(1)) ? wdata : mem[rd_ptr_inc];
      end else if (empty) begin
         head_nxt = wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         count <= count + CW'(push) - CW'(pop);
         if (push || pop) begin
            rdata <= head_nxt;
         end
      end
   end

endmodule

// File: rtl/endpoint_rx.sv
// Receive endpoint: per-VC buffering, round-robin drain to a local consumer,
// and credit / packet_sent return pulses towards the switch.
module endpoint_rx
   import chiplet_types_pkg::*;
#(
   parameter int NUM_VCS = 2,
   parameter int DEPTH   = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  flit_t                      flit_in,
   input  logic                       flit_valid,
   output logic [NUM_VCS-1:0]         credit_granted,
   output logic                       packet_sent,
   output flit_t                      rx_flit,
   output logic [$clog2(NUM_VCS)-1:0] rx_vc,
   output logic                       rx_valid,
   input  logic                       rx_ready,
   output logic                       overflow_err
);

   localparam int VCW = $clog2(NUM_VCS);
   localparam int CW  = $clog2(DEPTH) + 1;

   logic [NUM_VCS-1:0] push;
   logic [NUM_VCS-1:0] pop;
   logic [NUM_VCS-1:0] empty;
   logic [NUM_VCS-1:0] full;
   flit_t              rdata [NUM_VCS];
   logic [CW-1:0]      count [NUM_VCS];

   logic [VCW-1:0]     rr_ptr;
   logic [VCW-1:0]     pick;
   logic [VCW-1:0]     sel;
   logic [VCW-1:0]     hold_vc;
   logic [VCW-1:0]     in_vc;
   logic               hold;
   logic               fire;
   logic               vc_ok;
   logic               ovf_now;

   assign in_vc    = flit_in.vc[VCW-1:0];
   assign vc_ok    = (int'(flit_in.vc) < NUM_VCS);
   assign rx_valid = ~&empty;
   assign sel      = hold ? hold_vc : pick;
   assign fire     = rx_valid && rx_ready;
   assign rx_vc    = rx_valid ? sel : '0;
   assign rx_flit  = rx_valid ? rdata[sel] : '0;

   // Walk offsets from far to near so the VC closest to rr_ptr wins.
   always_comb begin
      pick = '0;
      for (int k = NUM_VCS - 1; k >= 0; k--) begin
         if (!empty[VCW'((int'(rr_ptr) + k) % NUM_VCS)]) begin
            pick = VCW'((int'(rr_ptr) + k) % NUM_VCS);
         end
      end
   end

   always_comb begin
      pop = '0;
      if (fire) begin
         pop[sel] = 1'b1;
      end
   end

   // A pop on the same VC frees the slot this cycle, so a full VC can still accept.
   always_comb begin
      push    = '0;
      ovf_now = 1'b0;
      if (flit_valid) begin
         if (!vc_ok) begin
            ovf_now = 1'b1;
         end else if (full[in_vc] && !pop[in_vc]) begin
            ovf_now = 1'b1;
         end else begin
            push[in_vc] = 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_VCS; i++) begin : g_vc
      vc_fifo #(
         .DEPTH  (DEPTH),
         .data_t (flit_t)
      ) u_fifo (
         .CLK   (CLK),
         .RST   (RST),
         .push  (push[i]),
         .pop   (pop[i]),
         .wdata (flit_in),
         .rdata (rdata[i]),
         .empty (empty[i]),
         .full  (full[i]),
         .count (count[i])
      );

      always_ff @(posedge CLK) begin
         if (!RST) begin
            a_count_range : assert (count[i] <= CW'(DEPTH));
         end
      end
   end

   // hold freezes the presented VC while the consumer stalls.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr         <= '0;
         hold           <= 1'b0;
         hold_vc        <= '0;
         credit_granted <= '0;
         packet_sent    <= 1'b0;
         overflow_err   <= 1'b0;
      end else begin
         hold           <= rx_valid && !rx_ready;
         hold_vc        <= sel;
         credit_granted <= pop;
         packet_sent    <= fire && flit_is_tail(rx_flit);
         if (ovf_now) begin
            overflow_err <= 1'b1;
         end
         if (fire) begin
            rr_ptr <= (int'(sel) == NUM_VCS - 1) ? '0 : sel + VCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_endpoint_rx.sv
// Directed bench for endpoint_rx with a queue-based reference model.
module tb_endpoint_rx;
   import chiplet_types_pkg::*;

   logic        CLK;
   logic        RST;
   flit_t       flit_in;
   logic        flit_valid;
   logic [1:0]  credit_granted;
   logic        packet_sent;
   flit_t       rx_flit;
   logic [0:0]  rx_vc;
   logic        rx_valid;
   logic        rx_ready;
   logic        overflow_err;

   endpoint_rx #(.NUM_VCS(2), .DEPTH(8)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .flit_in        (flit_in),
      .flit_valid     (flit_valid),
      .credit_granted (credit_granted),
      .packet_sent    (packet_sent),
      .rx_flit        (rx_flit),
      .rx_vc          (rx_vc),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .overflow_err   (overflow_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_c0 = 0;
   int cnt_c1 = 0;
   int cnt_ps = 0;
   int pop_log[$];

   // reference model state
   flit_t      mq [2][$];
   int         m_rr = 0;
   bit         m_hold = 0;
   int         m_hold_vc = 0;
   logic [1:0] m_credit = '0;
   bit         m_ps = 0;
   bit         m_ovf = 0;

   function automatic flit_t mk(int vc, bit tail, int data);
      flit_t f;
      f      = '0;
      f.vc   = vc_id_t'(vc);
      f.tail = tail;
      f.head = data[0];
      f.data = 16'(data);
      return f;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      bit    ev_valid;
      int    ev;
      bit    do_pop;
      flit_t f;
      ev_valid = (mq[0].size() != 0) || (mq[1].size() != 0);
      ev = 0;
      if (m_hold) ev = m_hold_vc;
      else begin
         for (int k = 1; k >= 0; k--) begin
            if (mq[(m_rr + k) % 2].size() != 0) ev = (m_rr + k) % 2;
         end
      end
      chk("rx_valid", 32'(rx_valid), 32'(ev_valid));
      if (ev_valid) begin
         chk("rx_vc", 32'(rx_vc), 32'(ev));
         chk("rx_flit", 32'(rx_flit), 32'(mq[ev][0]));
      end
      chk("credit_granted", 32'(credit_granted), 32'(m_credit));
      chk("packet_sent", 32'(packet_sent), 32'(m_ps));
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
      if (credit_granted[0]) cnt_c0++;
      if (credit_granted[1]) cnt_c1++;
      if (packet_sent) cnt_ps++;
      if (rx_valid && rx_ready && !RST) pop_log.push_back(int'(rx_vc));

      if (RST) begin
         mq[0].delete();
         mq[1].delete();
         m_rr = 0; m_hold = 0; m_hold_vc = 0;
         m_credit = '0; m_ps = 0; m_ovf = 0;
      end else begin
         do_pop    = ev_valid && rx_ready;
         m_credit  = do_pop ? (2'b01 << ev) : 2'b00;
         m_ps      = 0;
         m_hold    = ev_valid && !rx_ready;
         m_hold_vc = ev;
         if (do_pop) begin
            f    = mq[ev].pop_front();
            m_ps = f.tail;
            m_rr = (ev + 1) % 2;
         end
         if (flit_valid) begin
            if (int'(flit_in.vc) >= 2) m_ovf = 1;
            else if (mq[int'(flit_in.vc)].size() >= 8) m_ovf = 1;
            else mq[int'(flit_in.vc)].push_back(flit_in);
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic send(flit_t f);
      flit_valid = 1'b1;
      flit_in    = f;
      cycle();
      flit_valid = 1'b0;
      flit_in    = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      cycle();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1; flit_valid = 1'b0; flit_in = '0; rx_ready = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_flit", 32'(rx_flit), 32'd0);
      chk("rst_rx_vc", 32'(rx_vc), 32'd0);
      chk("rst_credit", 32'(credit_granted), 32'd0);
      chk("rst_packet_sent", 32'(packet_sent), 32'd0);
      chk("rst_overflow", 32'(overflow_err), 32'd0);

      // single tail flit on VC0
      rx_ready = 1'b1;
      send(mk(0, 1, 'hA5));
      chk("single_valid", 32'(rx_valid), 32'd1);
      chk("single_vc", 32'(rx_vc), 32'd0);
      chk("single_flit", 32'(rx_flit), 32'(mk(0, 1, 'hA5)));
      cycle();
      chk("single_credit", 32'(credit_granted), 32'b01);
      chk("single_ps", 32'(packet_sent), 32'd1);
      cycle();
      chk("single_credit_end", 32'(credit_granted), 32'b00);
      chk("single_ps_end", 32'(packet_sent), 32'd0);

      // out-of-range VC is dropped and flagged
      send(mk(3, 1, 'h77));
      chk("badvc_ovf", 32'(overflow_err), 32'd1);
      chk("badvc_valid", 32'(rx_valid), 32'd0);
      do_reset();

      // fill VC1, overflow on the ninth, then drain
      rx_ready = 1'b0;
      cnt_c1 = 0;
      for (int i = 0; i < 8; i++) send(mk(1, i == 7, 'h100 + i));
      send(mk(1, 1, 'h1FF));
      chk("fill_ovf", 32'(overflow_err), 32'd1);
      chk("fill_no_credit", 32'(cnt_c1), 32'd0);
      rx_ready = 1'b1;
      repeat (10) cycle();
      chk("fill_credits", 32'(cnt_c1), 32'd8);
      chk("fill_ovf_sticky", 32'(overflow_err), 32'd1);
      do_reset();

      // two VCs with three flits each: alternate
      rx_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(mk(i % 2, 1, 'h200 + i));
      pop_log.delete();
      rx_ready = 1'b1;
      repeat (8) cycle();
      chk("rr_count", 32'(pop_log.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < pop_log.size()) chk("rr_order", 32'(pop_log[i]), 32'(i % 2));
      end

      // backpressure: move RR pointer to VC1, then stall on a VC0 flit
      send(mk(0, 1, 'h2F0));
      cycle();
      rx_ready = 1'b0;
      send(mk(0, 0, 'h300));
      cnt_c0 = 0; cnt_c1 = 0;
      for (int i = 0; i < 5; i++) begin
         send(mk(1, i == 4, 'h310 + i));
         chk("bp_vc", 32'(rx_vc), 32'd0);
         chk("bp_flit", 32'(rx_flit), 32'(mk(0, 0, 'h300)));
      end
      chk("bp_no_credit", 32'(cnt_c0 + cnt_c1), 32'd0);
      rx_ready = 1'b1;
      cycle();
      chk("bp_first_credit", 32'(credit_granted), 32'b01);
      chk("bp_next_vc", 32'(rx_vc), 32'd1);
      repeat (6) cycle();

      // full VC0 with simultaneous pop and push
      rx_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(mk(0, i == 7, 'h400 + i));
      cnt_c0 = 0;
      rx_ready = 1'b1;
      send(mk(0, 1, 'h4FF));
      chk("full_pp_credit", 32'(credit_granted), 32'b01);
      chk("full_pp_ovf", 32'(overflow_err), 32'd0);
      rx_ready = 1'b0;
      cycle();
      chk("full_pp_one_pulse", 32'(credit_granted), 32'b00);
      rx_ready = 1'b1;
      repeat (10) cycle();
      chk("full_pp_total", 32'(cnt_c0), 32'd9);

      // reset in the middle of a 4-flit packet
      rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(mk(0, i == 3, 'h500 + i));
      rx_ready = 1'b1;
      cycle();
      cycle();
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      chk("mid_rst_valid", 32'(rx_valid), 32'd0);
      chk("mid_rst_credit", 32'(credit_granted), 32'd0);
      chk("mid_rst_ps", 32'(packet_sent), 32'd0);
      chk("mid_rst_flit", 32'(rx_flit), 32'd0);
      cnt_c0 = 0; cnt_ps = 0;
      repeat (5) cycle();
      chk("mid_rst_no_credit", 32'(cnt_c0), 32'd0);
      chk("mid_rst_no_ps", 32'(cnt_ps), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
